// File: rtl/cpu_press_gen.sv
// cpu_press_gen: computer-player button-press generator.
// A 10-bit maximal LFSR supplies a pseudo-random operand. The press FSM
// fires a one-cycle press when the difficulty level exceeds that operand,
// then holds off for GAP cycles before it may fire again.
module cpu_press_gen #(
    parameter int unsigned      WIDTH = 10,
    parameter int unsigned      GAP   = 3,
    parameter logic [WIDTH-1:0] SEED  = 10'h001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rand_out,
    output logic             press,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COOLDOWN = 2'd2
    } state_e;

    localparam logic [3:0] GAP_C = 4'(GAP);

    state_e           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [WIDTH-1:0] rand_q,  rand_d;
    logic             press_q, press_d;
    logic             busy_q,  busy_d;
    logic             hit;

    // Press condition: unsigned compare against the LFSR value before the edge
    assign hit = (level > rand_q);

    // LFSR next value: x^10+x^7+1, frozen while disabled, self-heals from zero
    always_comb begin
        rand_d = rand_q;
        if (rand_q == '0) begin
            rand_d = SEED;
        end else if (enable) begin
            rand_d = {rand_q[WIDTH-2:0], rand_q[9] ^ rand_q[6]};
        end
    end

    // State register plus all registered outputs, asynchronously cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rand_q  <= SEED;
            press_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rand_q  <= rand_d;
            press_q <= press_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and cooldown counter
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (hit) begin
                    state_d = COOLDOWN;
                    count_d = GAP_C;
                end
            end
            COOLDOWN: begin
                if (!enable) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        state_d = ARMED;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Registered-output next values; busy tracks the state being entered
    always_comb begin
        press_d = 1'b0;
        busy_d  = 1'b0;
        if ((state_q == ARMED) && enable && hit) begin
            press_d = 1'b1;
        end
        if (state_d == COOLDOWN) begin
            busy_d = 1'b1;
        end
    end

    assign rand_out = rand_q;
    assign press    = press_q;
    assign busy     = busy_q;

endmodule
